// File: rtl/imm_inserter.sv
// imm_inserter: scatters a 32-bit immediate into the RV32I immediate field of a
// base instruction word, flags immediates that cannot be represented, and
// presents the encoded word through a single registered valid/ready stage.
// Optional feature macro: IMM_INSERTER_LI_EXPAND_EN. When it is defined, an
// out-of-range ADDI immediate is split into a LUI + ADDI pair.
`timescale 1ns/1ps

module imm_inserter (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] base,
    input  logic [31:0] imm,
    input  logic [2:0]  imm_type,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        out_err,
    output logic [15:0] word_cnt
);

    localparam logic [2:0] I_TYPE       = 3'b000;
    localparam logic [2:0] B_TYPE       = 3'b001;
    localparam logic [2:0] S_TYPE       = 3'b010;
    localparam logic [2:0] U_TYPE       = 3'b011;
    localparam logic [2:0] J_TYPE       = 3'b100;
    localparam logic [2:0] SHAMT_TYPE   = 3'b101;
    localparam logic [2:0] CSR_TYPE     = 3'b110;
    localparam logic [2:0] DEFAULT_TYPE = 3'b111;

`ifdef IMM_INSERTER_LI_EXPAND_EN
    typedef enum logic [1:0] {EMPTY, FULL, PEND} state_t;
`else
    typedef enum logic [1:0] {EMPTY, FULL} state_t;
`endif

    state_t      state;
    state_t      next_state;
    logic [31:0] enc_word;
    logic        enc_err;
    logic        accept;
    logic        transfer;
    logic        load_new;
    logic        split_req;
    logic [31:0] first_word;
    logic        first_err;

    // Build the encoded word by keeping the non-immediate base bits and splicing in the immediate, plus the range check
    always_comb begin
        enc_word = base;
        enc_err  = 1'b0;
        case (imm_type)
            I_TYPE: begin
                enc_word = {imm[11:0], base[19:0]};
                enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
            end
            S_TYPE: begin
                enc_word = {imm[11:5], base[24:12], imm[4:0], base[6:0]};
                enc_err  = !((&imm[31:11]) || !(|imm[31:11]));
            end
            B_TYPE: begin
                enc_word = {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
                enc_err  = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
            end
            U_TYPE: begin
                enc_word = {imm[31:12], base[11:0]};
                enc_err  = |imm[11:0];
            end
            J_TYPE: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
                enc_err  = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
            end
            SHAMT_TYPE: begin
                enc_word = {base[31:25], imm[4:0], base[19:0]};
                enc_err  = |imm[31:5];
            end
            CSR_TYPE: begin
                enc_word = {base[31:20], imm[4:0], base[14:0]};
                enc_err  = |imm[31:5];
            end
            DEFAULT_TYPE: begin
                enc_word = base;
                enc_err  = 1'b0;
            end
            default: begin
                enc_word = base;
                enc_err  = 1'b0;
            end
        endcase
    end

`ifdef IMM_INSERTER_LI_EXPAND_EN
    logic [19:0] li_hi;
    logic [31:0] lui_word;
    logic [31:0] addi_word;
    logic [31:0] second_word;
    logic        load_second;

    // Work out the LUI/ADDI pair; adding 0x800 only carries into bit 12 when imm[11] is set, and the low part is always imm[11:0]
    always_comb begin
        li_hi     = imm[31:12] + {19'd0, imm[11]};
        lui_word  = {li_hi, base[11:7], 7'b0110111};
        addi_word = {imm[11:0], base[11:7], base[14:12], base[11:7], base[6:0]};
        split_req = (imm_type == I_TYPE) && (base[6:0] == 7'b0010011) &&
                    (base[14:12] == 3'b000) && enc_err;
    end
`else
    assign split_req = 1'b0;
`endif

    // Choose what gets loaded into the output register on an accept
    always_comb begin
        first_word = split_req ? lui_word_sel() : enc_word;
        first_err  = split_req ? 1'b0 : enc_err;
    end

    function automatic logic [31:0] lui_word_sel();
`ifdef IMM_INSERTER_LI_EXPAND_EN
        return lui_word;
`else
        return enc_word;
`endif
    endfunction

    assign out_valid = (state != EMPTY);
    assign in_ready  = (state == EMPTY) || ((state == FULL) && out_ready);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and load decisions for the output stage
    always_comb begin
        next_state = state;
        load_new   = 1'b0;
`ifdef IMM_INSERTER_LI_EXPAND_EN
        load_second = 1'b0;
`endif
        case (state)
            EMPTY: begin
                if (accept) begin
                    load_new = 1'b1;
`ifdef IMM_INSERTER_LI_EXPAND_EN
                    next_state = split_req ? PEND : FULL;
`else
                    next_state = FULL;
`endif
                end
            end
            FULL: begin
                if (out_ready) begin
                    if (accept) begin
                        load_new = 1'b1;
`ifdef IMM_INSERTER_LI_EXPAND_EN
                        next_state = split_req ? PEND : FULL;
`else
                        next_state = FULL;
`endif
                    end else begin
                        next_state = EMPTY;
                    end
                end
            end
`ifdef IMM_INSERTER_LI_EXPAND_EN
            PEND: begin
                if (out_ready) begin
                    load_second = 1'b1;
                    next_state  = FULL;
                end
            end
`endif
            default: begin
                next_state = EMPTY;
            end
        endcase
    end

    // Output word, error flag, held second word and transfer counter
    always_ff @(posedge clk) begin
        if (rst) begin
            out      <= 32'd0;
            out_err  <= 1'b0;
            word_cnt <= 16'd0;
`ifdef IMM_INSERTER_LI_EXPAND_EN
            second_word <= 32'd0;
`endif
        end else begin
            if (transfer) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (load_new) begin
                out     <= first_word;
                out_err <= first_err;
`ifdef IMM_INSERTER_LI_EXPAND_EN
                second_word <= addi_word;
`endif
            end
`ifdef IMM_INSERTER_LI_EXPAND_EN
            if (load_second) begin
                out     <= second_word;
                out_err <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_imm_inserter.sv
// tb_imm_inserter: directed and randomized stimulus for imm_inserter, checked
// against a queue-based model that encodes from the RV32I field layout.
`timescale 1ns/1ps

module tb_imm_inserter;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base;
    logic [31:0] imm;
    logic [2:0]  imm_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out;
    logic        out_err;
    logic [15:0] word_cnt;

    typedef struct {
        logic [31:0] w;
        logic        e;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] seen_w[$];
    logic        seen_e[$];
    int          seen_cyc[$];
    int          model_cnt;
    int          total;
    int          bad;
    int          cyc;

    imm_inserter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .base      (base),
        .imm       (imm),
        .imm_type  (imm_type),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .out_err   (out_err),
        .word_cnt  (word_cnt)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used for throughput checks
    initial cyc = 0;
    always @(posedge clk) cyc++;

    // Counts a comparison and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Reference model: encode from the immediate's bit positions and numeric range, queueing the expected words
    task automatic pushExpected(input logic [31:0] b, input logic [31:0] i, input logic [2:0] t);
        int          s;
        logic [31:0] w;
        logic        e;
        logic [31:0] hi;
        logic [31:0] rd;
        s = $signed(i);
        w = b;
        e = 1'b0;
        case (t)
            3'd0: begin
                w = (b & 32'h000FFFFF) | (i << 20);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd2: begin
                w = (b & 32'h01FFF07F) | (((i >> 5) & 32'h7F) << 25) | ((i & 32'h1F) << 7);
                e = !(s >= -2048 && s <= 2047);
            end
            3'd1: begin
                w = (b & 32'h01FFF07F) | (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25)
                    | (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7);
                e = !(s >= -4096 && s <= 4095) || (i % 2 != 0);
            end
            3'd3: begin
                w = (b & 32'h00000FFF) | (i & 32'hFFFFF000);
                e = (i % 4096) != 0;
            end
            3'd4: begin
                w = (b & 32'h00000FFF) | (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21)
                    | (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12);
                e = !(s >= -1048576 && s <= 1048575) || (i % 2 != 0);
            end
            3'd5: begin
                w = (b & ~32'h01F00000) | ((i & 32'h1F) << 20);
                e = i > 31;
            end
            3'd6: begin
                w = (b & ~32'h000F8000) | ((i & 32'h1F) << 15);
                e = i > 31;
            end
            default: begin
                w = b;
                e = 1'b0;
            end
        endcase
`ifdef IMM_INSERTER_LI_EXPAND_EN
        if (t == 3'd0 && (b & 32'h707F) == 32'h13 && e) begin
            hi = (i + 32'h800) >> 12;
            rd = (b >> 7) & 32'h1F;
            exp_q.push_back('{(hi << 12) | (rd << 7) | 32'h37, 1'b0});
            exp_q.push_back('{((i - (hi << 12)) << 20) | (rd << 15) | (rd << 7) | 32'h13, 1'b0});
            return;
        end
`endif
        exp_q.push_back('{w, e});
    endtask

    // Monitor: compare handshake, counter and data against the model each cycle, then advance the model
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
        end else begin
            checkOutput("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
            checkOutput("in_ready", {31'd0, in_ready},
                        {31'd0, (exp_q.size() == 0) || (exp_q.size() == 1 && out_ready)});
            checkOutput("word_cnt", {16'd0, word_cnt}, model_cnt & 32'hFFFF);
            if (exp_q.size() > 0) begin
                checkOutput("out", out, exp_q[0].w);
                checkOutput("out_err", {31'd0, out_err}, {31'd0, exp_q[0].e});
            end
            if (out_valid && out_ready && exp_q.size() > 0) begin
                seen_w.push_back(out);
                seen_e.push_back(out_err);
                seen_cyc.push_back(cyc);
                void'(exp_q.pop_front());
                model_cnt++;
            end
            if (in_valid && in_ready) begin
                pushExpected(base, imm, imm_type);
            end
        end
    end

    // Present one request and hold it until accepted (bounded), then drop valid
    task automatic applyStimulus(input logic [31:0] b, input logic [31:0] i, input logic [2:0] t);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        base     = b;
        imm      = i;
        imm_type = t;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput("accept_timeout", {31'd0, ok}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Hard time limit so the run always ends
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        model_cnt = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        base      = 32'd0;
        imm       = 32'd0;
        imm_type  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_out", out, 32'd0);
        checkOutput("rst_err", {31'd0, out_err}, 32'd0);
        checkOutput("rst_cnt", {16'd0, word_cnt}, 32'd0);
        @(posedge clk);
        #1;

        // Directed encodings, issued back to back with the consumer always ready
        applyStimulus(32'h00000093, 32'hFFFFFFFF, 3'd0);
        applyStimulus(32'h00000063, 32'h00000008, 3'd1);
        applyStimulus(32'h0020A023, 32'hFFFFFFFC, 3'd2);
        applyStimulus(32'h00000037, 32'h12345000, 3'd3);
        applyStimulus(32'h0000006F, 32'h00100000, 3'd4);
        applyStimulus(32'h00000063, 32'h00000003, 3'd1);
        applyStimulus(32'h00000293, 32'h12345FFF, 3'd0);
        repeat (4) @(posedge clk);
        #1;
        if (seen_w.size() >= 7) begin
            checkOutput("i_word", seen_w[0], 32'hFFF00093);
            checkOutput("i_err", {31'd0, seen_e[0]}, 32'd0);
            checkOutput("b_word", seen_w[1], 32'h00000463);
            checkOutput("s_word", seen_w[2], 32'hFE20AE23);
            checkOutput("s_err", {31'd0, seen_e[2]}, 32'd0);
            checkOutput("b2s_gap", seen_cyc[2] - seen_cyc[1], 32'd1);
            checkOutput("u_word", seen_w[3], 32'h12345037);
            checkOutput("j_err", {31'd0, seen_e[4]}, 32'd1);
            checkOutput("b_odd_err", {31'd0, seen_e[5]}, 32'd1);
`ifdef IMM_INSERTER_LI_EXPAND_EN
            checkOutput("li_count", seen_w.size(), 32'd8);
            if (seen_w.size() >= 8) begin
                checkOutput("li_lui", seen_w[6], 32'h123462B7);
                checkOutput("li_addi", seen_w[7], 32'hFFF28293);
                checkOutput("li_err", {31'd0, seen_e[6] | seen_e[7]}, 32'd0);
            end
`else
            checkOutput("li_count", seen_w.size(), 32'd7);
            checkOutput("li_word", seen_w[6], 32'hFFF00293);
            checkOutput("li_err", {31'd0, seen_e[6]}, 32'd1);
`endif
        end else begin
            checkOutput("directed_count", seen_w.size(), 32'd7);
        end

        // Backpressure: one word held, a second request waits five cycles
        seen_w.delete();
        seen_e.delete();
        seen_cyc.delete();
        out_ready = 1'b0;
        applyStimulus(32'h00000013, 32'h00000005, 3'd0);
        in_valid = 1'b1;
        base     = 32'h00000033;
        imm      = 32'h0;
        imm_type = 3'd7;
        repeat (5) begin
            @(negedge clk);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            checkOutput("bp_out", out, 32'h00500013);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("bp_count", seen_w.size(), 32'd2);
        if (seen_w.size() == 2) begin
            checkOutput("bp_first", seen_w[0], 32'h00500013);
            checkOutput("bp_second", seen_w[1], 32'h00000033);
            checkOutput("bp_gap", seen_cyc[1] - seen_cyc[0], 32'd1);
        end

        // Reset while a word is waiting on the output
        out_ready = 1'b0;
        applyStimulus(32'h00000013, 32'h00000007, 3'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("mid_rst_cnt", {16'd0, word_cnt}, 32'd0);
        checkOutput("mid_rst_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Randomized traffic with random backpressure
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            imm_type  = 3'($urandom_range(0, 7));
            base      = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                base = (base & ~32'h707F) | 32'h13;
            end
            case ($urandom_range(0, 3))
                0: imm = 32'($signed($urandom_range(0, 64)) - 32);
                1: imm = 32'($urandom_range(0, 1)) ? (32'h1 << $urandom_range(0, 31)) : -(32'h1 << $urandom_range(0, 31));
                2: imm = $urandom;
                default: imm = $urandom & 32'hFFFFF000;
            endcase
            @(posedge clk);
            #1;
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("drain_empty", {31'd0, out_valid}, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_inserter.md
Name: imm_inserter

Overview:
- Inverse of the decode-side immediate extraction.
- Takes a base instruction word (opcode/funct/register fields, immediate fields don't-care) plus a 32-bit immediate and immediate type.
- Scatters the immediate into the RV32I bit positions for that type, checks it is representable, and emits the encoded word.
- Feeds the self-test program loader and the trap-handler stub generator; valid/ready on both sides, one registered output stage.

Parameters:
- I_TYPE, 3'b000, I-type and jalr immediate (12-bit signed)
- B_TYPE, 3'b001, branch offset (13-bit signed, even)
- S_TYPE, 3'b010, store offset (12-bit signed)
- U_TYPE, 3'b011, lui/auipc upper immediate
- J_TYPE, 3'b100, jal offset (21-bit signed, even)
- SHAMT_TYPE, 3'b101, shift amount (5-bit unsigned)
- CSR_TYPE, 3'b110, zimm (5-bit unsigned, bits 19:15)
- DEFAULT_TYPE, 3'b111, no immediate; base passed through

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid and in_ready are both 1
- base  in  32  instruction word; immediate bit positions ignored
- imm  in  32  immediate value, two's complement
- imm_type  in  3  encoding per parameters
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer ready
- out  out  32  encoded instruction
- out_err  out  1  immediate not representable; qualified by out_valid
- word_cnt  out  16  count of output transfers (out_valid and out_ready), wraps at 0xFFFF to 0

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): out_valid=0, out=0, out_err=0, word_cnt=0, FSM to EMPTY, pending word discarded.
- in_ready = (state==EMPTY) or (state==FULL and out_ready); always 0 in PEND.
- Latency: accepted request appears on out at the next edge.
- Out stability: out and out_err hold stable while out_valid=1 and out_ready=0.
- Throughput: accept and drain in the same cycle, giving 1 word per cycle.
- Immediate-field clearing: base bits in the type's immediate field are cleared before insertion.
  - I: 31:20
  - S and B: 31:25 and 11:7
  - U: 31:12
  - J: 31:12
  - SHAMT: 24:20 (bits 31:25 of base kept, so srai funct7 survives)
  - CSR: 19:15
  - DEFAULT: none
- Insertion:
  - I: [31:20]=imm[11:0]
  - S: [31:25]=imm[11:5], [11:7]=imm[4:0]
  - B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]
  - U: [31:12]=imm[31:12]
  - J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12]
  - SHAMT: [24:20]=imm[4:0]
  - CSR: [19:15]=imm[4:0]
- out_err=1 when:
  - I/S: imm[31:11] not all equal
  - B: imm[31:12] not all equal, or imm[0]=1
  - J: imm[31:20] not all equal, or imm[0]=1
  - U: imm[11:0] != 0
  - SHAMT/CSR: imm[31:5] != 0
  - DEFAULT: never
- On error the word is still emitted, using the truncated bits above.
- FSM:
  - EMPTY: on accept go to FULL.
  - FULL: on out_ready with a new accept, stay FULL; on out_ready with no accept, go to EMPTY.
  - PEND: exists only with the optional feature.
- word_cnt increments once per output transfer, including each word of a split pair.

Optional Feature:
- Macro: IMM_INSERTER_LI_EXPAND_EN.
- Trigger: defined, imm_type==I_TYPE, base is ADDI (base[6:0]=7'b0010011, base[14:12]=3'b000), and imm fails the I range check.
- Split into two words, no error:
  - hi = (imm + 32'h800) >> 12; lo = imm - (hi << 12).
  - Word 1: LUI rd, hi = {hi[19:0], base[11:7], 7'b0110111}.
  - Word 2: ADDI rd, rd, lo, with rs1 replaced by base[11:7].
- State sequence: word 1 is presented in PEND; on out_ready go to FULL with word 2.
- in_ready=0 throughout PEND.
- rst in PEND drops word 2.
- Not defined: no PEND state, no split; the out-of-range case follows the normal out_err rule.

Test Plan:
- I: base=0x00000093, imm=0xFFFFFFFF, I_TYPE -> next cycle out=0xFFF00093, out_err=0, word_cnt 0->1 on drain.
- B/S: base=0x00000063, imm=8, B_TYPE -> out=0x00000463; then base=0x0020A023, imm=0xFFFFFFFC, S_TYPE -> out=0xFE20AE23, both err=0, back-to-back at 1 word/cycle.
- Range: J_TYPE, imm=0x00100000 -> out_err=1; B_TYPE, imm=3 -> out_err=1; U_TYPE, imm=0x12345000, base=0x00000037 -> out=0x12345037, err=0.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> out stable, in_ready=0, word_cnt unchanged; release -> one transfer per cycle, no request lost.
- Reset mid-stream: assert rst while out_valid=1 -> next cycle out_valid=0, word_cnt=0, in_ready=1.
- LI expansion, base=0x00000293, imm=0x12345FFF, I_TYPE:
  - With macro: words 0x123462B7 then 0xFFF28293, err=0, in_ready=0 between them.
  - Without macro: out=0xFFF00293, out_err=1.
